// File: rtl/cortexm0_wic_param_if.sv
// Signal bundle between the WIC and its neighbours (core WIC port, interrupt bus, PMU).
// The master side drives requests and masks; the WIC (slave) drives wake-up and handshake status.
interface cortexm0_wic_param_if #(
    parameter int WIDTH = 34
);
    logic             WICLOAD;
    logic             WICCLEAR;
    logic [WIDTH-1:0] WICINT;
    logic [WIDTH-1:0] WICMASK;
    logic             WICENREQ;
    logic             WICDSACKn;
    logic             WAKEUP;
    logic [WIDTH-1:0] WICSENSE;
    logic [WIDTH-1:0] WICPEND;
    logic             WICDSREQn;
    logic             WICENACK;

    modport master (
        output WICLOAD, WICCLEAR, WICINT, WICMASK, WICENREQ, WICDSACKn,
        input  WAKEUP, WICSENSE, WICPEND, WICDSREQn, WICENACK
    );

    modport slave (
        input  WICLOAD, WICCLEAR, WICINT, WICMASK, WICENREQ, WICDSACKn,
        output WAKEUP, WICSENSE, WICPEND, WICDSREQn, WICENACK
    );
endinterface

// File: rtl/cortexm0_wic_param.sv
// Wake-up interrupt controller: PMU/core enable handshake plus masked, sticky wake-up capture.
//
// state | meaning
// OFF   | WIC disabled, waiting for PMU enable request
// REQ   | requesting deep-sleep from core, waiting for its acknowledge
// ON    | enabled; masked events are pended and raise WAKEUP
// DRAIN | PMU released the request; waiting for core to drop its acknowledge
module cortexm0_wic_param #(
    parameter int WIDTH     = 34,
    parameter int EDGE_MODE = 0
) (
    input  logic                  FCLK,
    input  logic                  nRESET,
    cortexm0_wic_param_if.slave   wic
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_REQ,
        ST_ON,
        ST_DRAIN
    } state_t;

    localparam logic EDGE_SEL = (EDGE_MODE != 0);

    state_t           state;
    state_t           state_nxt;
    logic             dsreq_n;
    logic             dsreq_n_nxt;
    logic             enack;
    logic             enack_nxt;
    logic [WIDTH-1:0] sense;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] int_q;
    logic [WIDTH-1:0] evt;

    always_ff @(posedge FCLK) begin
        if (!nRESET) begin
            state   <= ST_OFF;
            dsreq_n <= 1'b1;
            enack   <= 1'b0;
        end else begin
            state   <= state_nxt;
            dsreq_n <= dsreq_n_nxt;
            enack   <= enack_nxt;
        end
    end

    // Outputs are registered alongside the state; DRAIN keeps whatever ENACK it inherited.
    always_comb begin
        state_nxt   = state;
        dsreq_n_nxt = dsreq_n;
        enack_nxt   = enack;
        case (state)
            ST_OFF: begin
                if (wic.WICENREQ) begin
                    state_nxt   = ST_REQ;
                    dsreq_n_nxt = 1'b0;
                    enack_nxt   = 1'b0;
                end
            end
            ST_REQ: begin
                if (!wic.WICDSACKn) begin
                    state_nxt   = ST_ON;
                    dsreq_n_nxt = 1'b0;
                    enack_nxt   = 1'b1;
                end else if (!wic.WICENREQ) begin
                    state_nxt   = ST_DRAIN;
                    dsreq_n_nxt = 1'b1;
                end
            end
            ST_ON: begin
                if (!wic.WICENREQ) begin
                    state_nxt   = ST_DRAIN;
                    dsreq_n_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (wic.WICDSACKn) begin
                    state_nxt   = ST_OFF;
                    dsreq_n_nxt = 1'b1;
                    enack_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt   = ST_OFF;
                dsreq_n_nxt = 1'b1;
                enack_nxt   = 1'b0;
            end
        endcase
    end

    // In level mode the previous-sample mask is forced to zero, so evt is the raw request.
    assign evt = wic.WICINT & ~(int_q & {WIDTH{EDGE_SEL}});

    always_ff @(posedge FCLK) begin
        if (!nRESET) begin
            sense <= '0;
            pend  <= '0;
            int_q <= '0;
        end else begin
            int_q <= wic.WICINT;
            if (wic.WICCLEAR) begin
                sense <= '0;
                pend  <= '0;
            end else if (wic.WICLOAD) begin
                sense <= wic.WICMASK;
                pend  <= '0;
            end else if (state == ST_ON) begin
                pend <= pend | (sense & evt);
            end
        end
    end

    assign wic.WAKEUP    = |pend;
    assign wic.WICSENSE  = sense;
    assign wic.WICPEND   = pend;
    assign wic.WICDSREQn = dsreq_n;
    assign wic.WICENACK  = enack;

endmodule

// File: tb/tb_cortexm0_wic_param.sv
// Bench for cortexm0_wic_param: four instances (34-bit level, 34-bit edge, 1-bit, 64-bit)
// driven from per-scenario tables; expected outputs are queued as stimulus is applied.
module tb_cortexm0_wic_param;

    logic FCLK = 1'b0;
    logic nRESET;

    always #5 FCLK = ~FCLK;

    cortexm0_wic_param_if #(.WIDTH(34)) if_lvl ();
    cortexm0_wic_param_if #(.WIDTH(34)) if_edg ();
    cortexm0_wic_param_if #(.WIDTH(1))  if_w1 ();
    cortexm0_wic_param_if #(.WIDTH(64)) if_w64 ();

    cortexm0_wic_param #(.WIDTH(34), .EDGE_MODE(0)) u_lvl (.FCLK(FCLK), .nRESET(nRESET), .wic(if_lvl));
    cortexm0_wic_param #(.WIDTH(34), .EDGE_MODE(1)) u_edg (.FCLK(FCLK), .nRESET(nRESET), .wic(if_edg));
    cortexm0_wic_param #(.WIDTH(1),  .EDGE_MODE(0)) u_w1  (.FCLK(FCLK), .nRESET(nRESET), .wic(if_w1));
    cortexm0_wic_param #(.WIDTH(64), .EDGE_MODE(0)) u_w64 (.FCLK(FCLK), .nRESET(nRESET), .wic(if_w64));

    typedef struct packed {
        logic        dsreq_n;
        logic        enack;
        logic        wakeup;
        logic [63:0] sense;
        logic [63:0] pend;
    } obs_t;

    // ctl = {load, clear, enreq, dsackn}
    typedef struct {
        logic [3:0]  ctl;
        logic [63:0] mask;
        logic [63:0] intr;
        obs_t        exp;
    } row_t;

    localparam logic [63:0] Z  = 64'd0;
    localparam logic [63:0] A  = 64'h3_FFFF_FFFF;
    localparam logic [63:0] B  = 64'h2_0000_0000;

    int    checks = 0;
    int    errors = 0;
    obs_t  exp_q[$];
    int    who_q[$];
    string tag_q[$];

    function automatic obs_t mk(logic [1:0] hs, logic [63:0] sense, logic [63:0] pend);
        obs_t o;
        o.dsreq_n = hs[1];
        o.enack   = hs[0];
        o.wakeup  = (pend != 64'd0);
        o.sense   = sense;
        o.pend    = pend;
        return o;
    endfunction

    function automatic row_t rw(logic [3:0] ctl, logic [63:0] mask, logic [63:0] intr, obs_t e);
        row_t r;
        r.ctl  = ctl;
        r.mask = mask;
        r.intr = intr;
        r.exp  = e;
        return r;
    endfunction

    function automatic obs_t obs_of(int which);
        obs_t o;
        o = '0;
        case (which)
            0: begin
                o.dsreq_n = if_lvl.WICDSREQn; o.enack = if_lvl.WICENACK; o.wakeup = if_lvl.WAKEUP;
                o.sense = 64'(if_lvl.WICSENSE); o.pend = 64'(if_lvl.WICPEND);
            end
            1: begin
                o.dsreq_n = if_edg.WICDSREQn; o.enack = if_edg.WICENACK; o.wakeup = if_edg.WAKEUP;
                o.sense = 64'(if_edg.WICSENSE); o.pend = 64'(if_edg.WICPEND);
            end
            2: begin
                o.dsreq_n = if_w1.WICDSREQn; o.enack = if_w1.WICENACK; o.wakeup = if_w1.WAKEUP;
                o.sense = 64'(if_w1.WICSENSE); o.pend = 64'(if_w1.WICPEND);
            end
            default: begin
                o.dsreq_n = if_w64.WICDSREQn; o.enack = if_w64.WICENACK; o.wakeup = if_w64.WAKEUP;
                o.sense = if_w64.WICSENSE; o.pend = if_w64.WICPEND;
            end
        endcase
        return o;
    endfunction

    task automatic drive(int which, row_t r);
        case (which)
            0: begin
                {if_lvl.WICLOAD, if_lvl.WICCLEAR, if_lvl.WICENREQ, if_lvl.WICDSACKn} = r.ctl;
                if_lvl.WICMASK = r.mask[33:0]; if_lvl.WICINT = r.intr[33:0];
            end
            1: begin
                {if_edg.WICLOAD, if_edg.WICCLEAR, if_edg.WICENREQ, if_edg.WICDSACKn} = r.ctl;
                if_edg.WICMASK = r.mask[33:0]; if_edg.WICINT = r.intr[33:0];
            end
            2: begin
                {if_w1.WICLOAD, if_w1.WICCLEAR, if_w1.WICENREQ, if_w1.WICDSACKn} = r.ctl;
                if_w1.WICMASK = r.mask[0:0]; if_w1.WICINT = r.intr[0:0];
            end
            default: begin
                {if_w64.WICLOAD, if_w64.WICCLEAR, if_w64.WICENREQ, if_w64.WICDSACKn} = r.ctl;
                if_w64.WICMASK = r.mask; if_w64.WICINT = r.intr;
            end
        endcase
    endtask

    task automatic push(int which, obs_t e, string tag);
        exp_q.push_back(e);
        who_q.push_back(which);
        tag_q.push_back(tag);
    endtask

    task automatic step();
        @(posedge FCLK);
        @(negedge FCLK);
    endtask

    task automatic test_reset();
        row_t r;
        obs_t e, g;
        int w;
        string t;
        nRESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) nRESET = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (c < 2)
                    r = rw(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom}, mk(2'b10, Z, Z));
                else
                    r = rw(4'b0001, Z, Z, mk(2'b10, Z, Z));
                drive(k, r);
                push(k, r.exp, $sformatf("reset%0d", c));
            end
            step();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); w = who_q.pop_front(); t = tag_q.pop_front(); g = obs_of(w);
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL %s dut%0d got dsreq_n=%b enack=%b wakeup=%b sense=%h pend=%h want dsreq_n=%b enack=%b wakeup=%b sense=%h pend=%h",
                             t, w, g.dsreq_n, g.enack, g.wakeup, g.sense, g.pend, e.dsreq_n, e.enack, e.wakeup, e.sense, e.pend);
                end
            end
        end
    endtask

    task automatic test_handshake();
        row_t rows[$];
        obs_t e, g;
        int w;
        string t;
        rows.push_back(rw(4'b0011, Z, Z, mk(2'b00, Z, Z)));
        rows.push_back(rw(4'b0011, Z, Z, mk(2'b00, Z, Z)));
        rows.push_back(rw(4'b0011, Z, Z, mk(2'b00, Z, Z)));
        rows.push_back(rw(4'b0010, Z, Z, mk(2'b01, Z, Z)));
        rows.push_back(rw(4'b0010, Z, Z, mk(2'b01, Z, Z)));
        rows.push_back(rw(4'b0000, Z, Z, mk(2'b11, Z, Z)));
        rows.push_back(rw(4'b0010, Z, Z, mk(2'b11, Z, Z)));
        rows.push_back(rw(4'b0001, Z, Z, mk(2'b10, Z, Z)));
        rows.push_back(rw(4'b0001, Z, Z, mk(2'b10, Z, Z)));
        rows.push_back(rw(4'b0011, Z, Z, mk(2'b00, Z, Z)));
        rows.push_back(rw(4'b0001, Z, Z, mk(2'b10, Z, Z)));
        rows.push_back(rw(4'b0001, Z, Z, mk(2'b10, Z, Z)));
        rows.push_back(rw(4'b0011, Z, Z, mk(2'b00, Z, Z)));
        rows.push_back(rw(4'b0001, Z, Z, mk(2'b10, Z, Z)));
        rows.push_back(rw(4'b0001, Z, Z, mk(2'b10, Z, Z)));
        foreach (rows[i]) begin
            drive(0, rows[i]);
            push(0, rows[i].exp, $sformatf("handshake%0d", i));
            step();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); w = who_q.pop_front(); t = tag_q.pop_front(); g = obs_of(w);
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL %s dut%0d got dsreq_n=%b enack=%b wakeup=%b sense=%h pend=%h want dsreq_n=%b enack=%b wakeup=%b sense=%h pend=%h",
                             t, w, g.dsreq_n, g.enack, g.wakeup, g.sense, g.pend, e.dsreq_n, e.enack, e.wakeup, e.sense, e.pend);
                end
            end
        end
    endtask

    task automatic test_level();
        row_t rows[$];
        obs_t e, g;
        int w;
        string t;
        rows.push_back(rw(4'b1011, 64'h5, Z, mk(2'b00, 64'h5, Z)));
        rows.push_back(rw(4'b0010, Z, Z, mk(2'b01, 64'h5, Z)));
        rows.push_back(rw(4'b0010, Z, 64'h6, mk(2'b01, 64'h5, 64'h4)));
        rows.push_back(rw(4'b0010, Z, Z, mk(2'b01, 64'h5, 64'h4)));
        rows.push_back(rw(4'b0110, Z, Z, mk(2'b01, Z, Z)));
        rows.push_back(rw(4'b1010, 64'h5, 64'h5, mk(2'b01, 64'h5, Z)));
        rows.push_back(rw(4'b0010, Z, 64'h3_0000_0001, mk(2'b01, 64'h5, 64'h1)));
        rows.push_back(rw(4'b0010, Z, A, mk(2'b01, 64'h5, 64'h5)));
        rows.push_back(rw(4'b1110, A, A, mk(2'b01, Z, Z)));
        rows.push_back(rw(4'b0000, Z, Z, mk(2'b11, Z, Z)));
        rows.push_back(rw(4'b0001, Z, Z, mk(2'b10, Z, Z)));
        foreach (rows[i]) begin
            drive(0, rows[i]);
            push(0, rows[i].exp, $sformatf("level%0d", i));
            step();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); w = who_q.pop_front(); t = tag_q.pop_front(); g = obs_of(w);
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL %s dut%0d got dsreq_n=%b enack=%b wakeup=%b sense=%h pend=%h want dsreq_n=%b enack=%b wakeup=%b sense=%h pend=%h",
                             t, w, g.dsreq_n, g.enack, g.wakeup, g.sense, g.pend, e.dsreq_n, e.enack, e.wakeup, e.sense, e.pend);
                end
            end
        end
    endtask

    task automatic test_gating();
        row_t rows[$];
        obs_t e, g;
        int w;
        string t;
        rows.push_back(rw(4'b1001, A, Z, mk(2'b10, A, Z)));
        rows.push_back(rw(4'b0001, Z, A, mk(2'b10, A, Z)));
        rows.push_back(rw(4'b0001, Z, A, mk(2'b10, A, Z)));
        rows.push_back(rw(4'b0011, Z, A, mk(2'b00, A, Z)));
        rows.push_back(rw(4'b0011, Z, A, mk(2'b00, A, Z)));
        rows.push_back(rw(4'b0010, Z, Z, mk(2'b01, A, Z)));
        rows.push_back(rw(4'b0010, Z, B, mk(2'b01, A, B)));
        rows.push_back(rw(4'b0000, Z, Z, mk(2'b11, A, B)));
        rows.push_back(rw(4'b0001, Z, A, mk(2'b10, A, B)));
        rows.push_back(rw(4'b0001, Z, A, mk(2'b10, A, B)));
        rows.push_back(rw(4'b0101, Z, Z, mk(2'b10, Z, Z)));
        foreach (rows[i]) begin
            drive(0, rows[i]);
            push(0, rows[i].exp, $sformatf("gating%0d", i));
            step();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); w = who_q.pop_front(); t = tag_q.pop_front(); g = obs_of(w);
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL %s dut%0d got dsreq_n=%b enack=%b wakeup=%b sense=%h pend=%h want dsreq_n=%b enack=%b wakeup=%b sense=%h pend=%h",
                             t, w, g.dsreq_n, g.enack, g.wakeup, g.sense, g.pend, e.dsreq_n, e.enack, e.wakeup, e.sense, e.pend);
                end
            end
        end
    endtask

    task automatic test_edge();
        row_t rows[$];
        obs_t e, g;
        int w;
        string t;
        rows.push_back(rw(4'b1011, 64'h1, Z, mk(2'b00, 64'h1, Z)));
        rows.push_back(rw(4'b0010, Z, Z, mk(2'b01, 64'h1, Z)));
        rows.push_back(rw(4'b0010, Z, 64'h1, mk(2'b01, 64'h1, 64'h1)));
        rows.push_back(rw(4'b0010, Z, 64'h1, mk(2'b01, 64'h1, 64'h1)));
        rows.push_back(rw(4'b1010, 64'h1, 64'h1, mk(2'b01, 64'h1, Z)));
        rows.push_back(rw(4'b0010, Z, 64'h1, mk(2'b01, 64'h1, Z)));
        rows.push_back(rw(4'b0010, Z, 64'h1, mk(2'b01, 64'h1, Z)));
        rows.push_back(rw(4'b0010, Z, Z, mk(2'b01, 64'h1, Z)));
        rows.push_back(rw(4'b0010, Z, 64'h1, mk(2'b01, 64'h1, 64'h1)));
        rows.push_back(rw(4'b0000, Z, 64'h1, mk(2'b11, 64'h1, 64'h1)));
        rows.push_back(rw(4'b0001, Z, Z, mk(2'b10, 64'h1, 64'h1)));
        rows.push_back(rw(4'b0101, Z, Z, mk(2'b10, Z, Z)));
        foreach (rows[i]) begin
            drive(1, rows[i]);
            push(1, rows[i].exp, $sformatf("edge%0d", i));
            step();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); w = who_q.pop_front(); t = tag_q.pop_front(); g = obs_of(w);
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL %s dut%0d got dsreq_n=%b enack=%b wakeup=%b sense=%h pend=%h want dsreq_n=%b enack=%b wakeup=%b sense=%h pend=%h",
                             t, w, g.dsreq_n, g.enack, g.wakeup, g.sense, g.pend, e.dsreq_n, e.enack, e.wakeup, e.sense, e.pend);
                end
            end
        end
    endtask

    task automatic test_abort();
        int   ids[3] = '{0, 2, 3};
        logic [63:0] m;
        row_t r;
        obs_t e, g;
        int w;
        string t;
        for (int s = 0; s < 5; s++) begin
            nRESET = (s == 3) ? 1'b0 : 1'b1;
            foreach (ids[k]) begin
                m = (ids[k] == 3) ? 64'h8000_0000_0000_0001 : 64'h1;
                case (s)
                    0: r = rw(4'b1011, m, Z, mk(2'b00, m, Z));
                    1: r = rw(4'b0010, Z, Z, mk(2'b01, m, Z));
                    2: r = rw(4'b0010, Z, m, mk(2'b01, m, m));
                    3: r = rw(4'b0010, Z, m, mk(2'b10, Z, Z));
                    default: r = rw(4'b0001, Z, Z, mk(2'b10, Z, Z));
                endcase
                drive(ids[k], r);
                push(ids[k], r.exp, $sformatf("abort%0d", s));
            end
            step();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); w = who_q.pop_front(); t = tag_q.pop_front(); g = obs_of(w);
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL %s dut%0d got dsreq_n=%b enack=%b wakeup=%b sense=%h pend=%h want dsreq_n=%b enack=%b wakeup=%b sense=%h pend=%h",
                             t, w, g.dsreq_n, g.enack, g.wakeup, g.sense, g.pend, e.dsreq_n, e.enack, e.wakeup, e.sense, e.pend);
                end
            end
        end
    endtask

    initial begin
        nRESET = 1'b0;
        for (int k = 0; k < 4; k++) drive(k, rw(4'b0001, Z, Z, mk(2'b10, Z, Z)));
        @(negedge FCLK);
        test_reset();
        test_handshake();
        test_level();
        test_gating();
        test_edge();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cortexm0_wic_param.md
# cortexm0_wic_param

Parametrised, functional Wake-up Interrupt Controller for the Cortex-M0 subsystem. It replaces the tie-off WIC with real behaviour. It holds a mask loaded from the core and runs the PMU/core deep-sleep enable handshake. While enabled, it latches masked interrupt requests, in level or rising-edge mode, and raises WAKEUP to the PMU. It sits between the core's WIC port, the system interrupt bus and the PMU, clocked by the always-on FCLK.

## Interface
- WIDTH, 34, number of wake-up sources (32 IRQ + NMI + RXEV); legal range 1..64
- EDGE_MODE, 0, 0 = level-sensitive capture, 1 = rising-edge capture (applies to all lines)
- FCLK  in  1  free-running clock; all flops on rising edge
- nRESET  in  1  reset, synchronous, active-low
- WICLOAD  in  1  load WICMASK into sense register (pulse from core)
- WICCLEAR  in  1  clear sense and pend registers (pulse from core)
- WICINT  in  WIDTH  interrupt requests from system, FCLK-synchronous
- WICMASK  in  WIDTH  wake-up mask from core
- WICENREQ  in  1  WIC enable request from PMU (level)
- WICDSACKn  in  1  deep-sleep acknowledge from core, active-low
- WAKEUP  out  1  wake-up request to PMU
- WICSENSE  out  WIDTH  current sense (mask) register
- WICPEND  out  WIDTH  pended wake-up events
- WICDSREQn  out  1  WIC enable request to core, active-low
- WICENACK  out  1  WIC enable acknowledge to PMU

## Operation
- Reset (nRESET=0 at an FCLK edge): state=OFF, sense=0, pend=0, int_q=0, WICDSREQn=1, WICENACK=0, WAKEUP=0. Reset mid-handshake or mid-pend aborts immediately to these values.
- Handshake FSM, with registered outputs:
  - OFF (DSREQn=1, ENACK=0): WICENREQ=1 -> REQ.
  - REQ (DSREQn=0, ENACK=0):
    - WICDSACKn=0 -> ON.
    - WICENREQ=0 first -> DRAIN.
  - ON (DSREQn=0, ENACK=1): WICENREQ=0 -> DRAIN.
  - DRAIN (DSREQn=1, ENACK unchanged from previous state): WICDSACKn=1 -> OFF (ENACK=0).
  - In DRAIN, WICENREQ re-asserting is ignored until OFF is reached.
- Sense register:
  - WICCLEAR=1 -> sense=0 and pend=0. WICCLEAR has priority over WICLOAD.
  - Else WICLOAD=1 -> sense=WICMASK and pend=0.
  - Both operations are accepted in any state.
- Event detect:
  - int_q registers WICINT every cycle.
  - EDGE_MODE=0: event = WICINT.
  - EDGE_MODE=1: event = WICINT & ~int_q.
- Pend capture:
  - Only in state ON, and only if neither WICCLEAR nor WICLOAD is asserted that cycle: pend |= sense & event.
  - Pend bits are sticky. They are retained through DRAIN/OFF until WICCLEAR, WICLOAD or reset.
- WAKEUP = |pend (combinational from the pend register); glitch-free.
- WICSENSE = sense, WICPEND = pend, both direct register outputs.

## Timing
- WICENREQ rise sampled at edge n -> WICDSREQn=0 after edge n.
- WICDSACKn=0 sampled at edge m in REQ -> WICENACK=1 after edge m.
- Release: WICENREQ=0 at edge k -> WICDSREQn=1 after k. WICDSACKn=1 at edge j>k -> WICENACK=0 after j.
- Capture latency: event present at edge e while ON -> WICPEND bit and WAKEUP high after edge e (1 cycle).
- Edge mode needs WICINT low for at least 1 sampled cycle between captures.
- In edge mode, a line already high when int_q=0 after reset counts as an edge on the first sampled cycle.
- WICLOAD/WICCLEAR take effect after the sampling edge. A simultaneous event in that cycle is dropped.

## Test plan
- Reset: hold nRESET=0 for 2 cycles with all inputs random -> WICDSREQn=1, WICENACK=0, WAKEUP=0, WICSENSE=0, WICPEND=0 the cycle after release.
- Handshake: WICENREQ=1 -> WICDSREQn=0 next cycle; WICDSACKn=0 3 cycles later -> WICENACK=1 next cycle; WICENREQ=0 -> WICDSREQn=1; WICDSACKn=1 -> WICENACK=0.
- Level capture (EDGE_MODE=0, WIDTH=34): WICLOAD with WICMASK=34'h0_0000_0005, state ON, WICINT=34'h6 for 1 cycle -> WICPEND=34'h4, WAKEUP=1; WICCLEAR -> WICPEND=0, WAKEUP=0, WICSENSE=0.
- Edge capture (EDGE_MODE=1): mask=bit0, hold WICINT[0]=1 for 5 cycles in ON, clear pend at cycle 3 -> pend re-sets only after WICINT[0] falls and rises again.
- Gating/priority: WICINT=all-ones with state OFF -> WICPEND stays 0. WICLOAD and WICCLEAR asserted together -> WICSENSE=0.
- Abort: reset asserted while in ON with WICPEND=34'h1 -> all outputs return to reset values on the next edge. Repeat with WIDTH=1 and WIDTH=64.
